// File: rtl/mem_loader.sv
// Streams a byte source into a data memory through a one-cycle-latency write strobe.
// Optional trailing checksum byte is checked when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader #(
   parameter int DEPTH = 1024,
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] length,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             load,
   output logic [7:0]       store,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] byte_count,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_LOAD = CHECK;
`else
   localparam state_t AFTER_LOAD = DONE;
`endif

   state_t           state_q, state_d;
   logic [LEN_W-1:0] target_q, target_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             load_q, load_d;
   logic [7:0]       store_q, store_d;
   logic             ready_q, ready_d;
   logic             xfer;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0]       sum_q, sum_d;
   logic             err_q, err_d;
`endif

   // Gating on count keeps a zero-length session from swallowing a source byte.
   always_comb begin
      in_ready = (state_q == LOAD) && (count_q != target_q);
`ifdef MEM_LOADER_CHECKSUM_EN
      if (state_q == CHECK) in_ready = 1'b1;
`endif
   end

   assign xfer = in_valid & in_ready;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      count_d  = count_q;
      load_d   = 1'b0;
      store_d  = 8'h00;
      ready_d  = ready_q;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               target_d = (length > DEPTH_L) ? DEPTH_L : length;
               count_d  = '0;
               ready_d  = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
               sum_d    = 8'h00;
               err_d    = 1'b0;
`endif
               state_d  = LOAD;
            end
         end
         LOAD: begin
            if (count_q == target_q) begin
               state_d = AFTER_LOAD;
            end else if (xfer) begin
               load_d  = 1'b1;
               store_d = in_byte;
               count_d = count_q + ONE_L;
`ifdef MEM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + in_byte;
`endif
               if (count_q + ONE_L == target_q) state_d = AFTER_LOAD;
            end
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (xfer) begin
               err_d   = ((sum_q + in_byte) != 8'h00);
               state_d = DONE;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // ready rises together with the done pulse and holds until the next start
      if (state_d == DONE && state_q != DONE) ready_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
         count_q  <= '0;
         load_q   <= 1'b0;
         store_q  <= 8'h00;
         ready_q  <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
         sum_q    <= 8'h00;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         count_q  <= count_d;
         load_q   <= load_d;
         store_q  <= store_d;
         ready_q  <= ready_d;
`ifdef MEM_LOADER_CHECKSUM_EN
         sum_q    <= sum_d;
         err_q    <= err_d;
`endif
      end
   end

   assign load       = load_q;
   assign store      = store_q;
   assign ready      = ready_q;
   assign busy       = (state_q == LOAD) || (state_q == CHECK);
   assign done       = (state_q == DONE);
   assign byte_count = count_q;
`ifdef MEM_LOADER_CHECKSUM_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule
